ec_scalar_mult: RTL and testbench

Left-to-right double-and-add scalar multiplier computing Q = k·P over a prime-field curve. It sits directly above the affine point-operation stage: it sequences doubling and addition requests to that stage over a request/done handshake, and consumes the (x3, y3) results. It resolves every case the point stage cannot handle internally, so that stage only ever sees finite, distinct-x (add) or finite, y≠0 (double) operands. These cases are point at infinity, P+P, and P+(−P).

---
 rtl/ec_scalar_mult.sv | 161 ++++++++++++++++
 tb/tb_ec_scalar_mult.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_scalar_mult.sv
// Left-to-right double-and-add scalar multiplier sequencing an external affine point stage.
// Optional ECSM_CONST_TIME_EN: issue (and discard) a dummy add for every zero scalar bit.
module ec_scalar_mult #(
  parameter int n  = 231,
  parameter int KW = n
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [n-1:0]  px,
  input  logic [n-1:0]  py,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  qx,
  output logic [n-1:0]  qy,
  output logic          q_inf,
  output logic          op_start,
  output logic          op_dbl,
  output logic [n-1:0]  op_x1,
  output logic [n-1:0]  op_y1,
  output logic [n-1:0]  op_x2,
  output logic [n-1:0]  op_y2,
  input  logic          op_done,
  input  logic [n-1:0]  op_x3,
  input  logic [n-1:0]  op_y3
);
  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, DBL_CHK, DBL_WAIT, ADD_CHK, ADD_WAIT, NEXT, FIN} state_t;
  state_t state, state_n;

  logic [KW-1:0] kr;
  logic [n-1:0]  pxr, pyr, qxr, qyr, qx_n, qy_n;
  logic          qinf, qinf_n, dummy, dummy_n;
  logic [IW-1:0] idx, idx_n;
  logic          issue, issue_dbl;
  logic [n-1:0]  ix1, iy1, ix2, iy2;

  always_comb begin
    state_n   = state;
    qx_n      = qxr;
    qy_n      = qyr;
    qinf_n    = qinf;
    idx_n     = idx;
    dummy_n   = dummy;
    issue     = 1'b0;
    issue_dbl = 1'b0;
    ix1       = qxr;
    iy1       = qyr;
    ix2       = pxr;
    iy2       = pyr;
    case (state)
      IDLE: if (start) begin
        state_n = SCAN;
        qinf_n  = 1'b1;
        qx_n    = '0;
        qy_n    = '0;
        idx_n   = IW'(KW - 1);
      end
      SCAN: begin
        if (kr[idx]) begin
          qx_n = pxr; qy_n = pyr; qinf_n = 1'b0;
          state_n = NEXT;
        end else if (idx == '0) state_n = FIN;
        else idx_n = idx - IW'(1);
      end
      NEXT: begin
        if (idx == '0) state_n = FIN;
        else begin
          idx_n   = idx - IW'(1);
          state_n = DBL_CHK;
        end
      end
      DBL_CHK: begin
        state_n = ADD_CHK;
        if (qinf) ;
        else if (qyr == '0) begin
          qinf_n = 1'b1; qx_n = '0; qy_n = '0;
        end else begin
          issue = 1'b1; issue_dbl = 1'b1;
          state_n = DBL_WAIT;
        end
      end
      DBL_WAIT: if (op_done) begin
        qx_n = op_x3; qy_n = op_y3;
        state_n = ADD_CHK;
      end
      ADD_CHK: begin
        state_n = NEXT;
        if (!kr[idx]) begin
`ifdef ECSM_CONST_TIME_EN
          // Dummy add only when the stage could legally take it; result is dropped.
          if (!qinf && qxr != pxr) begin
            issue = 1'b1; dummy_n = 1'b1;
            state_n = ADD_WAIT;
          end
`endif
        end else if (qinf) begin
          qx_n = pxr; qy_n = pyr; qinf_n = 1'b0;
        end else if (qxr == pxr && qyr == pyr) begin
          if (pyr == '0) begin
            qinf_n = 1'b1; qx_n = '0; qy_n = '0;
          end else begin
            ix1 = pxr; iy1 = pyr;
            issue = 1'b1; issue_dbl = 1'b1; dummy_n = 1'b0;
            state_n = ADD_WAIT;
          end
        end else if (qxr == pxr) begin
          qinf_n = 1'b1; qx_n = '0; qy_n = '0;
        end else begin
          issue = 1'b1; dummy_n = 1'b0;
          state_n = ADD_WAIT;
        end
      end
      ADD_WAIT: if (op_done) begin
        if (!dummy) begin
          qx_n = op_x3; qy_n = op_y3;
        end
        dummy_n = 1'b0;
        state_n = NEXT;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      kr <= '0; pxr <= '0; pyr <= '0;
      qxr <= '0; qyr <= '0; qinf <= 1'b0;
      idx <= '0; dummy <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
      qx <= '0; qy <= '0; q_inf <= 1'b0;
      op_start <= 1'b0; op_dbl <= 1'b0;
      op_x1 <= '0; op_y1 <= '0; op_x2 <= '0; op_y2 <= '0;
    end else begin
      state <= state_n;
      qxr <= qx_n; qyr <= qy_n; qinf <= qinf_n;
      idx <= idx_n; dummy <= dummy_n;
      op_start <= issue;
      done <= (state_n == FIN);
      if (state == IDLE && start) begin
        kr <= k; pxr <= px; pyr <= py;
        busy <= 1'b1;
      end
      if (issue) begin
        op_dbl <= issue_dbl;
        op_x1 <= ix1; op_y1 <= iy1; op_x2 <= ix2; op_y2 <= iy2;
      end
      // Every entry into FIN leaves Q untouched, so the current Q is the result.
      if (state_n == FIN) begin
        busy  <= 1'b0;
        q_inf <= qinf;
        qx    <= qinf ? '0 : qxr;
        qy    <= qinf ? '0 : qyr;
      end
    end
  end
endmodule

// File: tb/tb_ec_scalar_mult.sv
// Bench for ec_scalar_mult on y^2 = x^3+2x+2 mod 17, P=(5,1), with a 3-cycle point-stage model.
module tb_ec_scalar_mult;
  localparam int N  = 8;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [KW-1:0] kin;
  logic [N-1:0]  px, py;
  logic          busy, done, q_inf, op_start, op_dbl, op_done;
  logic [N-1:0]  qx, qy, op_x1, op_y1, op_x2, op_y2, op_x3, op_y3;

  ec_scalar_mult #(.n(N), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k(kin), .px(px), .py(py),
    .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
    .op_start(op_start), .op_dbl(op_dbl),
    .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
    .op_done(op_done), .op_x3(op_x3), .op_y3(op_y3)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int ndbl = 0, nadd = 0, nviol = 0, pend = 0;

  typedef struct {
    logic [N-1:0] x, y;
    logic         inf;
    int           nd, na;
  } exp_t;
  exp_t sb[$];

  function automatic int md(int a);
    return ((a % 17) + 17) % 17;
  endfunction

  function automatic int inv17(int a);
    for (int b = 1; b < 17; b++) if (md(a * b) == 1) return b;
    return 0;
  endfunction

  task automatic ec_add(input bit i1, input int x1, input int y1, input bit i2, input int x2,
                        input int y2, output bit io, output int xo, output int yo);
    int l;
    io = 1'b0; xo = 0; yo = 0;
    if (i1) begin io = i2; xo = x2; yo = y2; end
    else if (i2) begin xo = x1; yo = y1; end
    else if (x1 == x2 && md(y1 + y2) == 0) io = 1'b1;
    else begin
      if (x1 == x2) l = md((3 * x1 * x1 + 2) * inv17(2 * y1));
      else          l = md((y2 - y1) * inv17(x2 - x1));
      xo = md(l * l - x1 - x2);
      yo = md(l * (x1 - xo) - y1);
    end
  endtask

  // Reference k*P by repeated addition, independent of the bit-serial schedule.
  task automatic ref_mult(input int kv, output exp_t e);
    bit i; int x, y;
    i = 1'b1; x = 0; y = 0;
    for (int c = 0; c < kv; c++) ec_add(i, x, y, 1'b0, 5, 1, i, x, y);
    e.x = N'(x); e.y = N'(y); e.inf = i; e.nd = 0; e.na = 0;
  endtask

  // Point-stage model: flags operands it could not handle.
  always @(posedge clk) begin
    bit io; int xo, yo;
    op_done <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) op_done <= 1'b1;
    end
    if (op_start) begin
      if (op_dbl) begin
        ndbl <= ndbl + 1;
        ec_add(1'b0, int'(op_x1), int'(op_y1), 1'b0, int'(op_x1), int'(op_y1), io, xo, yo);
        if (op_y1 == 0 || io) nviol <= nviol + 1;
      end else begin
        nadd <= nadd + 1;
        ec_add(1'b0, int'(op_x1), int'(op_y1), 1'b0, int'(op_x2), int'(op_y2), io, xo, yo);
        if (op_x1 == op_x2 || io) nviol <= nviol + 1;
      end
      op_x3 <= N'(xo); op_y3 <= N'(yo);
      pend <= 3;
    end
  end

  task automatic pulse_start(input logic [KW-1:0] kv);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; kin = kv; px = 8'd5; py = 8'd1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit got, output int lat);
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; lat = c + 1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; kin = '0; px = '0; py = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, op_start, op_dbl, q_inf} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, op_start, op_dbl, q_inf});
    end
    n_tests++;
    if ({qx, qy} !== '0) begin
      n_fail++; $display("FAIL reset_q: got %h expected 0", {qx, qy});
    end
    n_tests++;
    if ({op_x1, op_y1, op_x2, op_y2} !== '0) begin
      n_fail++; $display("FAIL reset_ops: got %h expected 0", {op_x1, op_y1, op_x2, op_y2});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_scalars;
    int ks[9] = '{0, 1, 2, 3, 19, 7, 10, 128, 255};
    int nd[9] = '{0, 0, 1, 1, 4, 2, 3, 7, 7};
`ifdef ECSM_CONST_TIME_EN
    int na[9] = '{0, 0, 1, 1, 3, 2, 3, 7, 7};
`else
    int na[9] = '{0, 0, 0, 1, 1, 2, 1, 0, 7};
`endif
    exp_t e, g;
    bit got; int lat, d0, a0, v0;
    for (int t = 0; t < 9; t++) begin
      ref_mult(ks[t], e);
      e.nd = nd[t]; e.na = na[t];
      sb.push_back(e);
      d0 = ndbl; a0 = nadd; v0 = nviol;
      pulse_start(KW'(ks[t]));
      wait_done(got, lat);
      n_tests++;
      if (!got) begin
        n_fail++; $display("FAIL done_timeout k=%0d: got no done expected done", ks[t]);
        continue;
      end
      g = sb.pop_front();
      n_tests++;
      if ({qx, qy, q_inf} !== {g.x, g.y, g.inf}) begin
        n_fail++; $display("FAIL result k=%0d: got (%0d,%0d,inf=%b) expected (%0d,%0d,inf=%b)",
                           ks[t], qx, qy, q_inf, g.x, g.y, g.inf);
      end
      n_tests++;
      if (ndbl - d0 != g.nd || nadd - a0 != g.na) begin
        n_fail++; $display("FAIL op_count k=%0d: got dbl=%0d add=%0d expected dbl=%0d add=%0d",
                           ks[t], ndbl - d0, nadd - a0, g.nd, g.na);
      end
      n_tests++;
      if (nviol != v0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL stage_ops k=%0d: got bad_ops=%0d busy=%b expected 0 0", ks[t], nviol - v0, busy);
      end
      if (ks[t] == 0) begin
        n_tests++;
        if (lat != KW + 1) begin
          n_fail++; $display("FAIL k0_latency: got %0d expected %0d", lat, KW + 1);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0) begin
          n_fail++; $display("FAIL done_pulse: got %b expected 0", done);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op;
    bit got, seen; int lat;
    exp_t e, g;
    pulse_start(8'd3);
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (op_start) begin got = 1'b1; break; end
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL mid_op_start: got no op_start expected op_start");
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_tests++;
    if ({busy, done, op_start, op_dbl, q_inf, qx, qy, op_x1, op_y1, op_x2, op_y2} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outs: got %h expected 0",
                         {busy, done, op_start, op_dbl, q_inf, qx, qy, op_x1, op_y1, op_x2, op_y2});
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy || op_start) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL late_op_done: got activity expected none");
    end
    ref_mult(3, e);
    sb.push_back(e);
    pulse_start(8'd3);
    wait_done(got, lat);
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL post_reset_timeout: got no done expected done");
    end else begin
      g = sb.pop_front();
      n_tests++;
      if ({qx, qy, q_inf} !== {g.x, g.y, g.inf}) begin
        n_fail++; $display("FAIL post_reset_k3: got (%0d,%0d,%b) expected (%0d,%0d,%b)", qx, qy, q_inf, g.x, g.y, g.inf);
      end
    end
  endtask

  task automatic test_busy_start;
    bit got, seen; int lat;
    exp_t e, g;
    ref_mult(2, e);
    sb.push_back(e);
    pulse_start(8'd2);
    @(negedge clk); @(negedge clk);
    start = 1'b1; kin = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(got, lat);
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL busy_timeout: got no done expected done");
    end else begin
      g = sb.pop_front();
      n_tests++;
      if ({qx, qy, q_inf} !== {g.x, g.y, g.inf}) begin
        n_fail++; $display("FAIL busy_start_result: got (%0d,%0d,%b) expected (%0d,%0d,%b)", qx, qy, q_inf, g.x, g.y, g.inf);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL busy_start_ignored: got second run expected none");
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_scalars;
    test_reset_mid_op;
    test_busy_start;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
